eb_pack: RTL and testbench
==========================

# eb_pack

Elastic-buffer width packer that sits directly downstream of the FIFO controller's read port. It consumes narrow words over a req/ack handshake and emits one wide word per RATIO accepted narrow words, also over req/ack. Internal double buffering (accumulator plus output register) sustains one narrow word per cycle with no bubbles when the consumer keeps `i_0_ack` high.

## Interface
Parameters:
- `WIDTH`, default 8: narrow word width in bits.
- `RATIO`, default 4: narrow words per wide word; legal range 2..16.
- `CNTW`, default 2: lane index width; must equal ceil(log2(RATIO)).

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset_n` input 1: reset; asynchronous, active-low.
- `t_0_req` input 1: upstream word valid.
- `t_0_ack` output 1: packer can accept (combinational).
- `t_0_data` input WIDTH: narrow word.
- `t_0_last` input 1: end of packet (only with `EB_PACK_LAST_EN`).
- `i_0_req` output 1: wide word valid (registered).
- `i_0_ack` input 1: downstream accepts.
- `i_0_data` output WIDTH*RATIO: wide word (registered).
- `i_0_keep` output RATIO: lane-valid mask (only with `EB_PACK_LAST_EN`).

## Operation
- Transfer on either side occurs when req && ack are both high in the same cycle.
- State:
  - accumulator `acc` of (RATIO-1)*WIDTH bits;
  - lane index `idx` of CNTW bits;
  - output register `i_0_data` with full flag `i_0_req`.
- Lane order: the first accepted word goes to lane 0 = `i_0_data[WIDTH-1:0]`; lane k goes to bits `[(k+1)*WIDTH-1 : k*WIDTH]`.
- Completing word: the word accepted at `idx == RATIO-1` (or with `t_0_last`=1 under the macro).
- Non-completing accept:
  - write `t_0_data` into acc lane `idx`;
  - `idx` <= `idx`+1.
- Completing accept:
  - `i_0_data` <= {`t_0_data`, acc lanes 0..idx-1}, with lanes above idx zeroed;
  - `i_0_req` <= 1;
  - `idx` <= 0;
  - acc lanes are not cleared.
- Acceptance rule: `t_0_ack` = (`idx` != RATIO-1) || !`i_0_req` || `i_0_ack`.
  - Under the macro, `t_0_ack` is additionally 0 when `t_0_last`=1 && `i_0_req` && !`i_0_ack`.
- Output handshake:
  - `i_0_req` falls after an output transfer unless a completing accept happens in the same cycle; in that case it stays 1 and `i_0_data` is reloaded.
  - `i_0_data` is held stable while `i_0_req` && !`i_0_ack`.
  - `i_0_req` never drops without a transfer.
- `t_0_data` is ignored when `t_0_req`=0. `t_0_req` may be held high while `t_0_ack`=0; nothing is accepted in that cycle.
- Arithmetic: `idx` wraps RATIO-1 -> 0 explicitly; it never counts past RATIO-1 for non-power-of-2 RATIO.

## Timing
- Reset values: `i_0_req`=0, `i_0_data`=0, `i_0_keep`=0, `idx`=0, `acc`=0.
- `t_0_ack` after reset: 1.
- Latency: completing word accepted at edge N -> `i_0_req`=1 and data valid after edge N.
- Throughput: with `i_0_ack` tied 1, one narrow word is accepted every cycle, and one wide word is produced every RATIO cycles.
- Backpressure: with `i_0_req`=1 and `i_0_ack`=0, up to RATIO-1 further words are accepted; `t_0_ack` then drops at `idx`==RATIO-1.
- Reset mid-operation: the partial accumulator and any pending output word are discarded immediately; `i_0_req` goes to 0 asynchronously.
- Combinational path `i_0_ack` -> `t_0_ack` exists by design. There is no combinational path from `t_0_req` to `i_0_req`.

## Configuration
- `EB_PACK_LAST_EN` defined:
  - `t_0_last` and `i_0_keep` ports exist.
  - An accept with `t_0_last`=1 completes the current word early.
  - `i_0_keep` gets bits 0..idx set and higher bits 0; higher data lanes are 0.
  - A full word gets `i_0_keep` = all ones.
- `EB_PACK_LAST_EN` undefined: both ports are absent, and only full RATIO-lane words are emitted.

## Test plan
Configuration for all scenarios: WIDTH=8, RATIO=4.
- Reset, then idle -> `i_0_req`=0, `i_0_data`=0, `t_0_ack`=1, held for 10 cycles.
- Stream 0x01..0x08 back-to-back with `i_0_ack`=1 -> `i_0_data`=0x04030201 the cycle after the 4th accept, then 0x08070605 exactly 4 cycles later; `t_0_ack` never drops.
- `i_0_ack`=0 after the first wide word, then stream 0x11..0x14 -> 0x11..0x13 are accepted; `t_0_ack`=0 at the 4th word, and `i_0_data` is held at 0x04030201. Raising `i_0_ack` gives an accept of 0x14 in the same cycle, and 0x14131211 is presented next cycle.
- Assert `reset_n`=0 mid-word after 2 accepts -> `i_0_req`=0 immediately. After release, 0xA0..0xA3 gives 0xA3A2A1A0, with no stale lanes.
- Random `t_0_req`/`i_0_ack` for 10k cycles against a scoreboard -> every narrow word appears exactly once, in order and in the correct lane.
- `EB_PACK_LAST_EN`: 0x55, 0x66 with `last` on 0x66 -> `i_0_data`=0x00006655, `i_0_keep`=4'b0011. The next word starts in lane 0.

Source files
------------

// File: rtl/eb_pack.sv
// eb_pack: elastic-buffer width packer.
//
// Accepts RATIO narrow words of WIDTH bits over a req/ack handshake and emits
// one wide word of WIDTH*RATIO bits, also over req/ack. The first accepted word
// lands in lane 0 (LSBs). An accumulator holds lanes 0..RATIO-2 while the
// output register holds the previous wide word, so a new word can be assembled
// while the last one waits downstream. This sustains one narrow word per cycle.
//
// Optional feature macro: EB_PACK_LAST_EN
//   Adds t_0_last/i_0_keep. An accept with t_0_last=1 closes the word early:
//   unused lanes are zero and i_0_keep marks the valid lanes.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   t_0_req/ack    upstream narrow-word handshake (t_0_ack is combinational)
//   t_0_data       narrow word
//   t_0_last       end of packet (EB_PACK_LAST_EN only)
//   i_0_req/ack    downstream wide-word handshake (i_0_req is registered)
//   i_0_data       wide word (registered)
//   i_0_keep       lane-valid mask (EB_PACK_LAST_EN only)
module eb_pack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4,
    parameter int unsigned CNTW  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   t_0_req,
    output logic                   t_0_ack,
    input  logic [WIDTH-1:0]       t_0_data,
`ifdef EB_PACK_LAST_EN
    input  logic                   t_0_last,
    output logic [RATIO-1:0]       i_0_keep,
`endif
    output logic                   i_0_req,
    input  logic                   i_0_ack,
    output logic [WIDTH*RATIO-1:0] i_0_data
);

    localparam int unsigned     AccW    = (RATIO - 1) * WIDTH;
    localparam logic [CNTW-1:0] LastIdx = CNTW'(RATIO - 1);

    logic [AccW-1:0]        acc_q, acc_d;
    logic [CNTW-1:0]        idx_q, idx_d;
    logic [WIDTH*RATIO-1:0] data_q, data_d;
    logic                   req_q, req_d;
`ifdef EB_PACK_LAST_EN
    logic [RATIO-1:0]       keep_q, keep_d;
`endif

    // Accumulator padded to full width so every lane can be indexed uniformly.
    logic [WIDTH*RATIO-1:0] acc_ext;
    logic                   last_word;
    logic                   accept;
    logic                   complete;
    logic                   out_xfer;

    assign acc_ext = {{WIDTH{1'b0}}, acc_q};

    always_comb begin
`ifdef EB_PACK_LAST_EN
        last_word = t_0_last;
`else
        last_word = 1'b0;
`endif
        // The final lane can only be taken if the output register is free or
        // is being drained in this same cycle.
        t_0_ack = (idx_q != LastIdx) || !req_q || i_0_ack;
`ifdef EB_PACK_LAST_EN
        // An early-closing word needs the output register just like a full one.
        if (t_0_last && req_q && !i_0_ack) begin
            t_0_ack = 1'b0;
        end
`endif
        accept   = t_0_req && t_0_ack;
        complete = accept && ((idx_q == LastIdx) || last_word);
        out_xfer = req_q && i_0_ack;
    end

    always_comb begin
        acc_d  = acc_q;
        idx_d  = idx_q;
        data_d = data_q;
        req_d  = req_q;
`ifdef EB_PACK_LAST_EN
        keep_d = keep_q;
`endif
        if (out_xfer) begin
            req_d = 1'b0;
        end
        if (complete) begin
            // Lanes below idx come from the accumulator, lane idx is the
            // incoming word, anything above is zero. acc is left as is.
            data_d = '0;
`ifdef EB_PACK_LAST_EN
            keep_d = '0;
`endif
            for (int unsigned k = 0; k < RATIO; k++) begin
                if (CNTW'(k) < idx_q) begin
                    data_d[k*WIDTH +: WIDTH] = acc_ext[k*WIDTH +: WIDTH];
`ifdef EB_PACK_LAST_EN
                    keep_d[k] = 1'b1;
`endif
                end else if (CNTW'(k) == idx_q) begin
                    data_d[k*WIDTH +: WIDTH] = t_0_data;
`ifdef EB_PACK_LAST_EN
                    keep_d[k] = 1'b1;
`endif
                end
            end
            req_d = 1'b1;
            idx_d = '0;
        end else if (accept) begin
            // Non-completing accept: idx is below LastIdx here.
            for (int unsigned k = 0; k < RATIO - 1; k++) begin
                if (idx_q == CNTW'(k)) begin
                    acc_d[k*WIDTH +: WIDTH] = t_0_data;
                end
            end
            idx_d = idx_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
            req_q  <= 1'b0;
`ifdef EB_PACK_LAST_EN
            keep_q <= '0;
`endif
        end else begin
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            data_q <= data_d;
            req_q  <= req_d;
`ifdef EB_PACK_LAST_EN
            keep_q <= keep_d;
`endif
        end
    end

    assign i_0_req  = req_q;
    assign i_0_data = data_q;
`ifdef EB_PACK_LAST_EN
    assign i_0_keep = keep_q;
`endif

endmodule

// File: tb/tb_eb_pack.sv
// Testbench for eb_pack (WIDTH=8, RATIO=4). Expected wide words are pushed to a
// queue as narrow words are accepted and popped when the DUT hands a word off.
// Build with EB_PACK_LAST_EN defined to also exercise the early-close feature.
module tb_eb_pack;

    localparam int W  = 8;
    localparam int R  = 4;
    localparam int DW = W * R;

    logic          clk;
    logic          reset_n;
    logic          t_0_req;
    logic          t_0_ack;
    logic [W-1:0]  t_0_data;
    logic          t_0_last;
    logic          i_0_req;
    logic          i_0_ack;
    logic [DW-1:0] i_0_data;
`ifdef EB_PACK_LAST_EN
    logic [R-1:0]  i_0_keep;
`endif

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    logic [DW-1:0] exp_data[$];
    logic [R-1:0]  exp_keep[$];
    logic [W-1:0]  mdl_lane[R];
    int            mdl_cnt = 0;

    eb_pack #(
        .WIDTH(W),
        .RATIO(R),
        .CNTW (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .t_0_req (t_0_req),
        .t_0_ack (t_0_ack),
        .t_0_data(t_0_data),
`ifdef EB_PACK_LAST_EN
        .t_0_last(t_0_last),
        .i_0_keep(i_0_keep),
`endif
        .i_0_req (i_0_req),
        .i_0_ack (i_0_ack),
        .i_0_data(i_0_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Drive one cycle at the falling edge, let combinational outputs settle,
    // score any output hand-off and feed any accepted word into the model.
    task automatic drive_cycle(input logic req, input logic [W-1:0] d, input logic last,
                               input logic oack, output logic accepted);
        logic          last_eff;
        logic [DW-1:0] w;
        logic [R-1:0]  kp;
        logic [DW-1:0] e;
        logic [R-1:0]  ek;
        @(negedge clk);
        t_0_req  = req;
        t_0_data = d;
        t_0_last = last;
        i_0_ack  = oack;
        #1;
`ifdef EB_PACK_LAST_EN
        last_eff = last;
`else
        last_eff = 1'b0;
`endif
        if (i_0_req && i_0_ack) begin
            vectors++;
            if (exp_data.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got word %h, expected no word", i_0_data);
            end else begin
                e  = exp_data.pop_front();
                ek = exp_keep.pop_front();
                if (i_0_data !== e) begin
                    errors++;
                    $display("FAIL sb_data: got %h, expected %h", i_0_data, e);
                end
`ifdef EB_PACK_LAST_EN
                vectors++;
                if (i_0_keep !== ek) begin
                    errors++;
                    $display("FAIL sb_keep: got %b, expected %b", i_0_keep, ek);
                end
`endif
            end
        end
        accepted = t_0_req && t_0_ack;
        if (accepted) begin
            mdl_lane[mdl_cnt] = t_0_data;
            mdl_cnt++;
            if (mdl_cnt == R || last_eff) begin
                w  = '0;
                kp = '0;
                for (int k = 0; k < mdl_cnt; k++) begin
                    w[k*W +: W] = mdl_lane[k];
                    kp[k]       = 1'b1;
                end
                exp_data.push_back(w);
                exp_keep.push_back(kp);
                mdl_cnt = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        t_0_req = 1'b0;
        i_0_ack = 1'b0;
        exp_data.delete();
        exp_keep.delete();
        mdl_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic a;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, a);
            vectors++;
            if (i_0_req !== 1'b0 || i_0_data !== '0 || t_0_ack !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle c%0d: req=%b data=%h ack=%b, expected 0/0/1",
                         c, i_0_req, i_0_data, t_0_ack);
            end
`ifdef EB_PACK_LAST_EN
            vectors++;
            if (i_0_keep !== '0) begin
                errors++;
                $display("FAIL reset_keep: got %b, expected 0000", i_0_keep);
            end
`endif
        end
    endtask

    task automatic test_stream();
        logic a;
        for (int c = 0; c < 9; c++) begin
            if (c < 8) drive_cycle(1'b1, 8'(c + 1), 1'b0, 1'b1, a);
            else       drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, a);
            if (c < 8) begin
                vectors++;
                if (t_0_ack !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ack c%0d: got %b, expected 1", c, t_0_ack);
                end
            end
            if (c == 4) begin
                vectors++;
                if (i_0_req !== 1'b1 || i_0_data !== 32'h04030201) begin
                    errors++;
                    $display("FAIL stream_w0: req=%b data=%h, expected 1/04030201",
                             i_0_req, i_0_data);
                end
            end else if (c >= 5 && c <= 7) begin
                vectors++;
                if (i_0_req !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_gap c%0d: req=%b, expected 0", c, i_0_req);
                end
            end else if (c == 8) begin
                vectors++;
                if (i_0_req !== 1'b1 || i_0_data !== 32'h08070605) begin
                    errors++;
                    $display("FAIL stream_w1: req=%b data=%h, expected 1/08070605",
                             i_0_req, i_0_data);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic a;
        for (int c = 0; c < 4; c++) drive_cycle(1'b1, 8'(c + 1), 1'b0, 1'b0, a);
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b1, (c < 4) ? 8'(8'h11 + c) : 8'h14, 1'b0, 1'b0, a);
            vectors++;
            if (i_0_req !== 1'b1 || i_0_data !== 32'h04030201) begin
                errors++;
                $display("FAIL bp_hold c%0d: req=%b data=%h, expected 1/04030201",
                         c, i_0_req, i_0_data);
            end
            vectors++;
            if (a !== (c < 3)) begin
                errors++;
                $display("FAIL bp_accept c%0d: got %b, expected %b", c, a, (c < 3));
            end
        end
        drive_cycle(1'b1, 8'h14, 1'b0, 1'b1, a);
        vectors++;
        if (a !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: accept=%b, expected 1", a);
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, a);
        vectors++;
        if (i_0_req !== 1'b1 || i_0_data !== 32'h14131211) begin
            errors++;
            $display("FAIL bp_next: req=%b data=%h, expected 1/14131211", i_0_req, i_0_data);
        end
    endtask

    task automatic test_reset_mid();
        logic a;
        for (int c = 0; c < 6; c++) drive_cycle(1'b1, 8'(8'h21 + c), 1'b0, 1'b0, a);
        vectors++;
        if (i_0_req !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pending: req=%b, expected 1", i_0_req);
        end
        #2;
        reset_n = 1'b0;
        t_0_req = 1'b0;
        exp_data.delete();
        exp_keep.delete();
        mdl_cnt = 0;
        #1;
        vectors++;
        if (i_0_req !== 1'b0 || i_0_data !== '0 || t_0_ack !== 1'b1) begin
            errors++;
            $display("FAIL rmid_async: req=%b data=%h ack=%b, expected 0/0/1",
                     i_0_req, i_0_data, t_0_ack);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) drive_cycle(1'b1, 8'(8'hA0 + c), 1'b0, 1'b1, a);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, a);
        vectors++;
        if (i_0_req !== 1'b1 || i_0_data !== 32'hA3A2A1A0) begin
            errors++;
            $display("FAIL rmid_after: req=%b data=%h, expected 1/A3A2A1A0", i_0_req, i_0_data);
        end
    endtask

    task automatic test_random();
        logic          a;
        logic          rq;
        logic          ak;
        logic          lst;
        logic          exp_ack;
        logic          exp_req;
        logic          prev_hold = 1'b0;
        logic [DW-1:0] prev_data = '0;
        int            n;
        for (int c = 0; c < 10000; c++) begin
            rq  = ($urandom_range(0, 3) != 0);
            ak  = ($urandom_range(0, 2) != 0);
            lst = 1'b0;
`ifdef EB_PACK_LAST_EN
            lst = ($urandom_range(0, 7) == 0);
`endif
            exp_req = (exp_data.size() != 0);
            exp_ack = (mdl_cnt != R - 1) || !exp_req || ak;
`ifdef EB_PACK_LAST_EN
            if (lst && exp_req && !ak) exp_ack = 1'b0;
`endif
            drive_cycle(rq, 8'($urandom), lst, ak, a);
            vectors++;
            if (t_0_ack !== exp_ack || i_0_req !== exp_req) begin
                errors++;
                $display("FAIL rnd_hs c%0d: ack=%b req=%b, expected %b/%b",
                         c, t_0_ack, i_0_req, exp_ack, exp_req);
            end
            if (prev_hold) begin
                vectors++;
                if (i_0_data !== prev_data) begin
                    errors++;
                    $display("FAIL rnd_stable c%0d: got %h, expected %h", c, i_0_data, prev_data);
                end
            end
            prev_hold = i_0_req && !i_0_ack;
            prev_data = i_0_data;
        end
        n = 0;
        while (exp_data.size() != 0 && n < 10) begin
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, a);
            n++;
        end
        vectors++;
        if (exp_data.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: %0d words never delivered, expected 0", exp_data.size());
        end
    endtask

`ifdef EB_PACK_LAST_EN
    task automatic test_last();
        logic a;
        do_reset();
        drive_cycle(1'b1, 8'h55, 1'b0, 1'b0, a);
        drive_cycle(1'b1, 8'h66, 1'b1, 1'b0, a);
        drive_cycle(1'b1, 8'h77, 1'b1, 1'b0, a);
        vectors++;
        if (i_0_req !== 1'b1 || i_0_data !== 32'h00006655 || i_0_keep !== 4'b0011) begin
            errors++;
            $display("FAIL last_word: req=%b data=%h keep=%b, expected 1/00006655/0011",
                     i_0_req, i_0_data, i_0_keep);
        end
        vectors++;
        if (t_0_ack !== 1'b0) begin
            errors++;
            $display("FAIL last_stall: ack=%b, expected 0", t_0_ack);
        end
        for (int c = 0; c < 4; c++) drive_cycle(1'b1, 8'(8'h77 + 8'h11 * c), 1'b0, 1'b1, a);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, a);
        vectors++;
        if (i_0_req !== 1'b1 || i_0_data !== 32'hAA998877 || i_0_keep !== 4'b1111) begin
            errors++;
            $display("FAIL last_next: req=%b data=%h keep=%b, expected 1/AA998877/1111",
                     i_0_req, i_0_data, i_0_keep);
        end
    endtask
`endif

    initial begin
        reset_n  = 1'b0;
        t_0_req  = 1'b0;
        t_0_data = '0;
        t_0_last = 1'b0;
        i_0_ack  = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef EB_PACK_LAST_EN
        test_last();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
